// File: rtl/rv64_trap_ctrl.sv
// Machine-mode trap entry / mret sequencer driving the trap CSRs' dedicated write ports; accept -> CSR write (N+1) -> redirect (N+2).
// Backpressure: req_ready_o is high only in IDLE; requesters hold their event until it is accepted.
module rv64_trap_ctrl #(
    parameter int              XLEN            = 64,
    parameter logic [XLEN-1:0] IRQ_TIMER_CAUSE = 64'h8000_0000_0000_0007
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_valid_i,
    input  logic            irq_timer_i,
    input  logic [XLEN-1:0] irq_pc_i,
    output logic            req_ready_o,

    input  logic [XLEN-1:0] csr_mstatus_rd_i,
    input  logic [XLEN-1:0] csr_mepc_rd_i,
    input  logic [XLEN-1:0] csr_mtvec_rd_i,

    output logic [XLEN-1:0] csr_mstatus_o,
    output logic [XLEN-1:0] csr_mepc_o,
    output logic [XLEN-1:0] csr_mcause_o,
    output logic [XLEN-1:0] csr_mtval_o,
    output logic            csr_mstatus_valid_o,
    output logic            csr_mepc_valid_o,
    output logic            csr_mcause_valid_o,
    output logic            csr_mtval_valid_o,
    output logic            csr_write_block_o,

    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAP_WR = 2'd1,
        MRET_WR = 2'd2,
        REDIR   = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] epc;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } evt_t;

    state_t          state_q, state_d;
    evt_t            evt_q, evt_d;
    logic [XLEN-1:0] target_q, target_d;

    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] trap_vec;
    logic [XLEN-1:0] mstatus_trap;
    logic [XLEN-1:0] mstatus_mret;
    logic            irq_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            evt_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            evt_q    <= evt_d;
            target_q <= target_d;
        end
    end

    // Vectored mode only applies to interrupts; modes 2 and 3 fall back to direct.
    always_comb begin
        vec_base = {csr_mtvec_rd_i[XLEN-1:2], 2'b00};
        trap_vec = vec_base;
        if (csr_mtvec_rd_i[1:0] == 2'b01 && evt_q.cause[XLEN-1]) begin
            trap_vec = vec_base + {evt_q.cause[XLEN-3:0], 2'b00};
        end
    end

    always_comb begin
        mstatus_trap            = csr_mstatus_rd_i;
        mstatus_trap[MPIE_BIT]  = csr_mstatus_rd_i[MIE_BIT];
        mstatus_trap[MIE_BIT]   = 1'b0;
        mstatus_trap[12:11]     = 2'b11;

        mstatus_mret            = csr_mstatus_rd_i;
        mstatus_mret[MIE_BIT]   = csr_mstatus_rd_i[MPIE_BIT];
        mstatus_mret[MPIE_BIT]  = 1'b1;
        mstatus_mret[12:11]     = 2'b11;
    end

    assign irq_take = irq_timer_i && csr_mstatus_rd_i[MIE_BIT];

    always_comb begin
        state_d             = state_q;
        evt_d               = evt_q;
        target_d            = target_q;
        req_ready_o         = 1'b0;
        csr_mstatus_o       = '0;
        csr_mepc_o          = '0;
        csr_mcause_o        = '0;
        csr_mtval_o         = '0;
        csr_mstatus_valid_o = 1'b0;
        csr_mepc_valid_o    = 1'b0;
        csr_mcause_valid_o  = 1'b0;
        csr_mtval_valid_o   = 1'b0;
        csr_write_block_o   = 1'b0;
        redirect_valid_o    = 1'b0;
        redirect_pc_o       = '0;
        busy_o              = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (trap_valid_i) begin
                    evt_d   = '{epc: trap_pc_i, cause: trap_cause_i, tval: trap_tval_i};
                    state_d = TRAP_WR;
                end else if (mret_valid_i) begin
                    state_d = MRET_WR;
                end else if (irq_take) begin
                    evt_d   = '{epc: irq_pc_i, cause: IRQ_TIMER_CAUSE, tval: '0};
                    state_d = TRAP_WR;
                end
            end

            TRAP_WR: begin
                csr_mstatus_valid_o = 1'b1;
                csr_mepc_valid_o    = 1'b1;
                csr_mcause_valid_o  = 1'b1;
                csr_mtval_valid_o   = 1'b1;
                csr_mstatus_o       = mstatus_trap;
                csr_mepc_o          = {evt_q.epc[XLEN-1:2], 2'b00};
                csr_mcause_o        = evt_q.cause;
                csr_mtval_o         = evt_q.tval;
                csr_write_block_o   = 1'b1;
                busy_o              = 1'b1;
                target_d            = trap_vec;
                state_d             = REDIR;
            end

            MRET_WR: begin
                csr_mstatus_valid_o = 1'b1;
                csr_mstatus_o       = mstatus_mret;
                csr_write_block_o   = 1'b1;
                busy_o              = 1'b1;
                target_d            = csr_mepc_rd_i;
                state_d             = REDIR;
            end

            REDIR: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = target_q;
                busy_o           = 1'b1;
                state_d          = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv64_trap_ctrl.sv
// Directed bench for rv64_trap_ctrl: vector table for single events plus hand sequences
// for back-to-back acceptance, interrupt masking after entry, and reset mid-operation.
module tb_rv64_trap_ctrl;

    localparam int XLEN = 64;
    localparam logic [63:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            trap_valid_i = 1'b0;
    logic [XLEN-1:0] trap_cause_i = '0;
    logic [XLEN-1:0] trap_tval_i = '0;
    logic [XLEN-1:0] trap_pc_i = '0;
    logic            mret_valid_i = 1'b0;
    logic            irq_timer_i = 1'b0;
    logic [XLEN-1:0] irq_pc_i = '0;
    logic            req_ready_o;
    logic [XLEN-1:0] csr_mstatus_rd_i = '0;
    logic [XLEN-1:0] csr_mepc_rd_i = '0;
    logic [XLEN-1:0] csr_mtvec_rd_i = '0;
    logic [XLEN-1:0] csr_mstatus_o, csr_mepc_o, csr_mcause_o, csr_mtval_o;
    logic            csr_mstatus_valid_o, csr_mepc_valid_o, csr_mcause_valid_o, csr_mtval_valid_o;
    logic            csr_write_block_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            busy_o;

    rv64_trap_ctrl #(.XLEN(XLEN), .IRQ_TIMER_CAUSE(IRQ_CAUSE)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .trap_valid_i        (trap_valid_i),
        .trap_cause_i        (trap_cause_i),
        .trap_tval_i         (trap_tval_i),
        .trap_pc_i           (trap_pc_i),
        .mret_valid_i        (mret_valid_i),
        .irq_timer_i         (irq_timer_i),
        .irq_pc_i            (irq_pc_i),
        .req_ready_o         (req_ready_o),
        .csr_mstatus_rd_i    (csr_mstatus_rd_i),
        .csr_mepc_rd_i       (csr_mepc_rd_i),
        .csr_mtvec_rd_i      (csr_mtvec_rd_i),
        .csr_mstatus_o       (csr_mstatus_o),
        .csr_mepc_o          (csr_mepc_o),
        .csr_mcause_o        (csr_mcause_o),
        .csr_mtval_o         (csr_mtval_o),
        .csr_mstatus_valid_o (csr_mstatus_valid_o),
        .csr_mepc_valid_o    (csr_mepc_valid_o),
        .csr_mcause_valid_o  (csr_mcause_valid_o),
        .csr_mtval_valid_o   (csr_mtval_valid_o),
        .csr_write_block_o   (csr_write_block_o),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_pc_o       (redirect_pc_o),
        .busy_o              (busy_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        trap_v, mret_v, irq;
        logic [63:0] cause, tval, pc, irq_pc, mstatus, mepc, mtvec;
        logic        exp_trap, exp_mret;
        logic [63:0] e_ms, e_mepc, e_cause, e_tval, e_redir;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] valids();
        return {csr_mstatus_valid_o, csr_mepc_valid_o, csr_mcause_valid_o, csr_mtval_valid_o};
    endfunction

    function automatic vec_t mk(input string nm, input logic tv, input logic mv, input logic iq,
                                input logic [63:0] cause, input logic [63:0] tval,
                                input logic [63:0] pc, input logic [63:0] ipc,
                                input logic [63:0] ms, input logic [63:0] mepc,
                                input logic [63:0] mtvec, input logic et, input logic em,
                                input logic [63:0] e_ms, input logic [63:0] e_mepc,
                                input logic [63:0] e_cause, input logic [63:0] e_tval,
                                input logic [63:0] e_redir);
        vec_t v;
        v.name = nm; v.trap_v = tv; v.mret_v = mv; v.irq = iq;
        v.cause = cause; v.tval = tval; v.pc = pc; v.irq_pc = ipc;
        v.mstatus = ms; v.mepc = mepc; v.mtvec = mtvec;
        v.exp_trap = et; v.exp_mret = em;
        v.e_ms = e_ms; v.e_mepc = e_mepc; v.e_cause = e_cause; v.e_tval = e_tval; v.e_redir = e_redir;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        trap_valid_i = v.trap_v; mret_valid_i = v.mret_v; irq_timer_i = v.irq;
        trap_cause_i = v.cause;  trap_tval_i = v.tval;    trap_pc_i = v.pc;
        irq_pc_i = v.irq_pc;     csr_mstatus_rd_i = v.mstatus;
        csr_mepc_rd_i = v.mepc;  csr_mtvec_rd_i = v.mtvec;
        #1;
        chk({v.name, " ready_at_accept"}, 64'(req_ready_o), 64'd1);
        if (!v.exp_trap && !v.exp_mret) begin
            for (int c = 0; c < 10; c++) begin
                tick();
                chk({v.name, " no_valids"}, {59'd0, valids(), redirect_valid_o}, 64'd0);
                chk({v.name, " ready_held"}, 64'(req_ready_o), 64'd1);
            end
            trap_valid_i = 1'b0; mret_valid_i = 1'b0; irq_timer_i = 1'b0;
            return;
        end
        tick();
        trap_valid_i = 1'b0; mret_valid_i = 1'b0; irq_timer_i = 1'b0;
        #1;
        chk({v.name, " wr_valids"}, 64'(valids()), v.exp_trap ? 64'hF : 64'h8);
        chk({v.name, " wr_block"}, 64'(csr_write_block_o), 64'd1);
        chk({v.name, " wr_ready"}, 64'(req_ready_o), 64'd0);
        chk({v.name, " wr_mstatus"}, csr_mstatus_o, v.e_ms);
        if (v.exp_trap) begin
            chk({v.name, " wr_mepc"}, csr_mepc_o, v.e_mepc);
            chk({v.name, " wr_mcause"}, csr_mcause_o, v.e_cause);
            chk({v.name, " wr_mtval"}, csr_mtval_o, v.e_tval);
        end
        tick();
        csr_mstatus_rd_i = v.e_ms;
        #1;
        chk({v.name, " redir_valid"}, 64'(redirect_valid_o), 64'd1);
        chk({v.name, " redir_pc"}, redirect_pc_o, v.e_redir);
        chk({v.name, " redir_block_valids"}, {59'd0, csr_write_block_o, valids()}, 64'd0);
        chk({v.name, " redir_busy"}, 64'(busy_o), 64'd1);
        tick();
        chk({v.name, " idle_after"}, {61'd0, redirect_valid_o, busy_o, req_ready_o}, 64'd1);
    endtask

    initial begin
        vecs[0] = mk("exc", 1, 0, 0, 64'd2, 64'hdead, 64'h8000_0040, 64'd0, 64'h8, 64'd0, 64'h8000_0100,
                     1, 0, 64'h1880, 64'h8000_0040, 64'd2, 64'hdead, 64'h8000_0100);
        vecs[1] = mk("irq_vec", 0, 0, 1, 64'd0, 64'd0, 64'd0, 64'h8000_0200, 64'h8, 64'd0, 64'h8000_0101,
                     1, 0, 64'h1880, 64'h8000_0200, IRQ_CAUSE, 64'd0, 64'h8000_011C);
        vecs[2] = mk("irq_masked", 0, 0, 1, 64'd0, 64'd0, 64'd0, 64'h8000_0200, 64'h0, 64'd0, 64'h8000_0101,
                     0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        vecs[3] = mk("mret", 0, 1, 0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h1880, 64'h8000_0044, 64'h8000_0100,
                     0, 1, 64'h1888, 64'd0, 64'd0, 64'd0, 64'h8000_0044);
        vecs[4] = mk("all_three", 1, 1, 1, 64'd5, 64'h1234, 64'h8000_0047, 64'h8000_0300, 64'h8, 64'h9999_0000,
                     64'h8000_0101, 1, 0, 64'h1880, 64'h8000_0044, 64'd5, 64'h1234, 64'h8000_0100);
        vecs[5] = mk("exc_msb_vec", 1, 0, 0, 64'h8000_0000_0000_0003, 64'h77, 64'h4000, 64'd0,
                     64'hA000_0000_0000_0088, 64'd0, 64'h1001, 1, 0, 64'hA000_0000_0000_1880,
                     64'h4000, 64'h8000_0000_0000_0003, 64'h77, 64'h100C);
        vecs[6] = mk("mret_mpie0", 0, 1, 0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h8, 64'h1234_5678_9ABC_DEF0,
                     64'h2003, 0, 1, 64'h1880, 64'd0, 64'd0, 64'd0, 64'h1234_5678_9ABC_DEF0);

        tick();
        chk("reset_outputs", {58'd0, valids(), csr_write_block_o, redirect_valid_o}, 64'd0);
        chk("reset_busy_ready", {62'd0, busy_o, req_ready_o}, 64'd1);
        rst = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // irq with mtvec mode 3 (treated as direct)
        run_vec(mk("irq_mode3", 0, 0, 1, 64'd0, 64'd0, 64'd0, 64'h5000, 64'h8, 64'd0, 64'h2003,
                   1, 0, 64'h1880, 64'h5000, IRQ_CAUSE, 64'd0, 64'h2000));

        // Held request: ignored while busy, re-accepted at N+3
        csr_mstatus_rd_i = 64'h8; csr_mtvec_rd_i = 64'h100;
        trap_valid_i = 1'b1; trap_cause_i = 64'd1; trap_tval_i = 64'd0; trap_pc_i = 64'h40;
        tick();
        chk("b2b_wr1", 64'(csr_mcause_valid_o), 64'd1);
        tick();
        chk("b2b_redir", {62'd0, redirect_valid_o, req_ready_o}, 64'h2);
        tick();
        chk("b2b_idle_n3", {62'd0, busy_o, req_ready_o}, 64'h1);
        tick();
        chk("b2b_wr2", 64'(csr_mcause_valid_o), 64'd1);
        trap_valid_i = 1'b0;
        tick();
        tick();

        // Interrupt pending through REDIR is masked by the new MIE=0
        csr_mstatus_rd_i = 64'h8; irq_timer_i = 1'b1; irq_pc_i = 64'h300;
        tick();
        chk("mask_wr_cause", csr_mcause_o, IRQ_CAUSE);
        csr_mstatus_rd_i = 64'h1880;
        tick();
        chk("mask_redir", 64'(redirect_valid_o), 64'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mask_stays_idle", {58'd0, valids(), busy_o, req_ready_o}, 64'd1);
        end
        irq_timer_i = 1'b0;

        // Reset during TRAP_WR aborts the event
        csr_mstatus_rd_i = 64'h8;
        trap_valid_i = 1'b1; trap_cause_i = 64'd4; trap_pc_i = 64'h80;
        tick();
        chk("rst_pre_wr", 64'(csr_write_block_o), 64'd1);
        rst = 1'b0;
        trap_valid_i = 1'b0;
        #1;
        chk("rst_async_outs", {58'd0, valids(), csr_write_block_o, redirect_valid_o}, 64'd0);
        chk("rst_async_data", csr_mstatus_o | csr_mepc_o | csr_mcause_o | redirect_pc_o, 64'd0);
        chk("rst_async_busy", 64'(busy_o), 64'd0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_no_redirect", {61'd0, redirect_valid_o, busy_o, req_ready_o}, 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
